// File: rtl/cg_auto_ctrl_if.sv
// Request/status bundle between the clock-gating controller and the blocks it gates.
// The gated-cycle counter signals exist only when CG_GATED_CNT_EN is defined.
interface cg_auto_ctrl_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned THR_W = 4
`ifdef CG_GATED_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
);

  logic [NCH-1:0]   req;
  logic             force_on;
  logic [THR_W-1:0] idle_thr;
  logic [NCH-1:0]   gclk;
  logic [NCH-1:0]   ch_en;
  logic [NCH-1:0]   ch_gated;

`ifdef CG_GATED_CNT_EN
  logic                 cnt_clr;
  logic [NCH*CNT_W-1:0] gated_cnt;

  modport master (
    output req, force_on, idle_thr, cnt_clr,
    input  gclk, ch_en, ch_gated, gated_cnt
  );
  modport slave (
    input  req, force_on, idle_thr, cnt_clr,
    output gclk, ch_en, ch_gated, gated_cnt
  );
`else
  modport master (
    output req, force_on, idle_thr,
    input  gclk, ch_en, ch_gated
  );
  modport slave (
    input  req, force_on, idle_thr,
    output gclk, ch_en, ch_gated
  );
`endif

endinterface

// File: rtl/cg_auto_ctrl.sv
// Multi-channel automatic clock gating: per-channel idle-hysteresis FSM driving a latch ICG.
// Define CG_GATED_CNT_EN to add saturating per-channel gated-cycle counters.
module cg_auto_ctrl #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned THR_W = 4
`ifdef CG_GATED_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic          clk_gt,
  input  logic          rst_n,
  cg_auto_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StOn = 2'd0, StDrain = 2'd1, StOff = 2'd2} st_e;

  st_e              state_q [NCH];
  st_e              state_d [NCH];
  logic [THR_W-1:0] idle_q  [NCH];
  logic [THR_W-1:0] idle_d  [NCH];
  logic [THR_W:0]   idle_inc[NCH];
  logic [NCH-1:0]   en_q, en_d, en_lat, act;
  logic [THR_W:0]   eff_thr;

  // A zero threshold behaves as one; the extra MSB keeps idle_cnt + 1 from wrapping.
  assign eff_thr = {1'b0, bus.idle_thr} | {{THR_W{1'b0}}, ~|bus.idle_thr};
  assign act     = bus.req | {NCH{bus.force_on}};

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      idle_inc[i] = {1'b0, idle_q[i]} + {{THR_W{1'b0}}, 1'b1};
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      idle_d[i]  = idle_q[i];
      en_d[i]    = en_q[i];
      unique case (state_q[i])
        StOn: begin
          if (act[i]) begin
            idle_d[i] = '0;
          end else if (eff_thr == {{THR_W{1'b0}}, 1'b1}) begin
            state_d[i] = StOff;
            en_d[i]    = 1'b0;
          end else begin
            state_d[i] = StDrain;
            idle_d[i]  = {{(THR_W-1){1'b0}}, 1'b1};
          end
        end
        StDrain: begin
          if (act[i]) begin
            state_d[i] = StOn;
            idle_d[i]  = '0;
          end else if (idle_inc[i] >= eff_thr) begin
            state_d[i] = StOff;
            en_d[i]    = 1'b0;
          end else begin
            idle_d[i] = idle_inc[i][THR_W-1:0];
          end
        end
        StOff: begin
          if (act[i]) begin
            state_d[i] = StOn;
            en_d[i]    = 1'b1;
            idle_d[i]  = '0;
          end
        end
        default: begin
          state_d[i] = StOn;
          en_d[i]    = 1'b1;
          idle_d[i]  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_gt or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= StOn;
        idle_q[i]  <= '0;
      end
      en_q <= '1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        idle_q[i]  <= idle_d[i];
      end
      en_q <= en_d;
    end
  end

  // Latch is closed while clk_gt is high, so gclk only ever sees whole high phases.
  always_latch begin
    if (!rst_n) begin
      en_lat = '1;
    end else if (!clk_gt) begin
      en_lat = en_q;
    end
  end

  assign bus.gclk  = {NCH{clk_gt}} & en_lat;
  assign bus.ch_en = en_q;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      bus.ch_gated[i] = (state_q[i] == StOff);
    end
  end

`ifdef CG_GATED_CNT_EN
  logic [CNT_W-1:0] cnt_q [NCH];

  always_ff @(posedge clk_gt or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.cnt_clr) begin
          cnt_q[i] <= '0;
        end else if (state_q[i] == StOff && cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cnt_out
    assign bus.gated_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: doc/cg_auto_ctrl.md
# cg_auto_ctrl

Parametrised multi-channel automatic clock-gating controller for the low-power clock-gating library. Each of NCH channels receives a glitch-free latch-based gated clock, derived from the free-running domain clock clk_gt. Gating is driven by a per-channel idle-hysteresis state machine, not a raw enable: a channel's clock is stopped only after a programmable number of consecutive idle cycles, and restarts one cycle after a request. It sits between the domain clock root and the register banks it powers down.

## Interface
- NCH, 4: number of gated channels (1..32)
- THR_W, 4: width of idle threshold and per-channel idle counter
- CNT_W, 16: width of per-channel gated-cycle counter (only with CG_GATED_CNT_EN)

- clk_gt  in  1  free-running domain clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NCH  per-channel activity request, synchronous to clk_gt
- force_on  in  1  global override, keeps all channels enabled
- idle_thr  in  THR_W  idle cycles before gating, sampled live every cycle
- gclk  out  NCH  gated clocks
- ch_en  out  NCH  registered enable per channel (pre-latch)
- ch_gated  out  NCH  1 when channel FSM is in OFF
- cnt_clr  in  1  synchronous clear of all gated-cycle counters (macro only)
- gated_cnt  out  NCH*CNT_W  channel i at bits [i*CNT_W +: CNT_W] (macro only)

## Operation
- Per channel, an independent FSM with states ON, DRAIN, OFF, an idle counter idle_cnt[THR_W] and a register en_q. All are updated on the posedge of clk_gt.
- act = req[i] | force_on. eff_thr = (idle_thr == 0) ? 1 : idle_thr.
- ON:
  - act → stay ON, idle_cnt = 0.
  - !act and eff_thr == 1 → OFF, en_q = 0.
  - otherwise → DRAIN, idle_cnt = 1.
- DRAIN:
  - act → ON, idle_cnt = 0.
  - else if idle_cnt + 1 >= eff_thr → OFF, en_q = 0.
  - else idle_cnt + 1.
  - The comparison uses THR_W+1 bits, so there is no wrap.
- OFF: act → ON, en_q = 1, idle_cnt = 0; else stay OFF.
- en_q = 1 in ON and DRAIN.
- ICG per channel:
  - en_lat is a latch, transparent while clk_gt is low.
  - gclk[i] = clk_gt & en_lat[i].
  - en_lat is forced to 1 while rst_n = 0.
  - en_lat never changes while clk_gt is high, so there are no glitches or truncated pulses.
- ch_en = en_q. ch_gated = (state == OFF).
- idle_thr change mid-DRAIN takes effect immediately. If idle_cnt + 1 >= new eff_thr, the channel goes to OFF on the next edge.
- If act is high in the same cycle the threshold would be reached, act wins and the channel goes to ON.
- force_on holds every channel in ON. On release, the normal idle count starts from 0.

## Timing
- Reset (rst_n low, asynchronous):
  - all FSMs ON, idle_cnt = 0, en_q = 1, en_lat = 1.
  - gclk = clk_gt; ch_en = all 1; ch_gated = 0; gated_cnt = 0.
  - Reset asserted mid-DRAIN or mid-OFF forces this state immediately.
- Gating latency:
  - Let req be last sampled high at edge k, and low from edge k+1 onward.
  - en_q falls at edge k + eff_thr.
  - The last gclk rising edge is at edge k + eff_thr.
  - No gclk rising edge occurs from k + eff_thr + 1 onward.
- Wake latency:
  - In OFF, req is sampled high at edge m, so en_q rises after edge m.
  - The first gclk rising edge is at edge m+1.
  - The requester holds data/valid at least through edge m+1.
- gclk high pulses are always full clk_gt high phases.

## Configuration
- CG_GATED_CNT_EN defined:
  - adds cnt_clr and gated_cnt.
  - gated_cnt[i] increments each edge where channel i is in OFF, saturating at all-ones.
  - cnt_clr = 1 zeroes all counters at that edge and has priority over increment.
- CG_GATED_CNT_EN undefined: the cnt_clr and gated_cnt ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, NCH=4, idle_thr=3, req=0 → gclk toggles during reset and for 3 edges after release, then ch_gated=4'hF and gclk stays low.
- Channel 0 in OFF, req[0] pulsed 1 cycle at edge m → ch_en[0]=1 after m, gclk[0] rises at m+1, m+2, m+3. It is re-gated after edge m+3 (idle_thr=3). Other channels stay gated.
- idle_thr=8, channel in DRAIN with idle_cnt=5, idle_thr changed to 4 → channel enters OFF at the next edge.
- idle_thr=0 → gating after exactly 1 idle cycle. req reasserts on the edge the threshold is hit → channel stays ON and gclk is uninterrupted.
- force_on=1 with req=0 for 20 cycles → all gclk run and ch_gated=0. After release with idle_thr=2 → all channels gate 2 edges later. rst_n pulsed low while channels are gated → gclk resumes immediately, asynchronously.
- With CG_GATED_CNT_EN, CNT_W=4 → gated_cnt saturates at 4'hF after 15 OFF cycles. cnt_clr asserted while in OFF → count reads 0 next cycle, then resumes incrementing.
